// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and constants for the data-memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Clears the byte-within-doubleword offset of a byte address.
  localparam logic [63:0] DW_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFF8;

  // Load data returned to the core on any error completion.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

  // Default bus timeout and the counter width it implies.
  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W           = $clog2(TIMEOUT_DEFAULT);

  // Counter width for an arbitrary timeout (timeout >= 2).
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_timeout.sv
`default_nettype none
// ============================================================================
// Module   : dmem_timeout
// Brief    : Saturating up-counter with clear/enable; hit flags TIMEOUT-1.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_timeout #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Count BUSY cycles; hold at LAST so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Brief    : Core load/store port to 64-bit req/ack memory bridge with stall,
//            load lane select, misaligned-load and bus-timeout errors.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [63:0]       cpu_wdata,
  input  logic [7:0]        cpu_wmask,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata
);

  localparam int TCNT_W = cnt_width(TIMEOUT);

  state_t            state, state_n;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wmask_q;
  logic [31:0]       rdata_q;

  logic capture;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_hit;
  logic load_ack;

  dmem_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (TCNT_W)
  ) u_timeout (
    .clk (clk),
    .rst (nrst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .hit (cnt_hit)
  );

  // State register; reset forces IDLE so mem_req drops without waiting for a clock.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state decode and the state-derived handshake outputs.
  always_comb begin
    state_n   = state;
    capture   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    cpu_stall = 1'b0;
    cpu_err   = 1'b0;
    mem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          cpu_stall = 1'b1;
          capture   = 1'b1;
          cnt_clr   = 1'b1;
          if (!cpu_we && (cpu_addr[1:0] != 2'b00)) state_n = ERR;
          else if (cpu_we && (cpu_wmask == 8'h00))  state_n = DONE;
          else                                      state_n = BUSY;
        end
      end
      BUSY: begin
        mem_req   = 1'b1;
        cpu_stall = 1'b1;
        cnt_en    = 1'b1;
        // An ack coinciding with the timeout compare still completes normally.
        if (mem_ack)      state_n = DONE;
        else if (cnt_hit) state_n = ERR;
      end
      DONE: state_n = IDLE;
      ERR: begin
        cpu_err = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Capture the request so the bus sees stable values for the whole transaction.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (capture) begin
      we_q    <= cpu_we;
      addr_q  <= cpu_addr;
      wdata_q <= cpu_wdata;
      wmask_q <= cpu_wmask;
    end
  end

  assign load_ack = (state == BUSY) && mem_ack && !we_q;

  // Latch the addressed 32-bit lane of a completed load; stores leave it alone.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst)          rdata_q <= '0;
    else if (load_ack) rdata_q <= addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  end

  assign cpu_rdata = (state == ERR) ? ERR_DATA : rdata_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q & DW_ALIGN_MASK[ADDR_W-1:0];
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wmask_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Brief    : Self-checking bench for dmem_ctrl (directed table, corner
//            sequences, randomized transactions against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERRD    = 32'h0000_0000;

  logic        clk;
  logic        nrst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic [7:0]  cpu_wmask;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  dmem_ctrl #(
    .ADDR_W   (32),
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (ERRD)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wmask (cpu_wmask),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cpu_err   (cpu_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Last load value the core should see (reference model state).
  logic [31:0] model_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          ack_at;   // BUSY cycle carrying mem_ack; 0 or >TIMEOUT = never
    logic [63:0] mrdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_stall;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: outcome of one transaction from the controller's rules.
  task automatic model(input logic we, input logic [31:0] addr, input logic [7:0] wmask,
                       input int ack_at, input logic [63:0] mrdata,
                       output logic [31:0] rd, output logic er, output int st);
    if (!we && (addr % 4 != 0)) begin
      rd = ERRD; er = 1'b1; st = 1;
    end else if (we && wmask == 8'h00) begin
      rd = model_rdata; er = 1'b0; st = 1;
    end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
      if (!we) model_rdata = ((addr / 4) % 2 == 1) ? mrdata[63:32] : mrdata[31:0];
      rd = model_rdata; er = 1'b0; st = 1 + ack_at;
    end else begin
      rd = ERRD; er = 1'b1; st = 1 + TIMEOUT;
    end
  endtask

  // Present one request and act as memory until the core is released.
  // Returns at negedge+1 of the completion (DONE/ERR) cycle with cpu_req still high.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, input int ack_at, input logic [63:0] mrdata,
                         input logic ack_in_done,
                         output int stall_n, output int req_n, output logic [31:0] rd,
                         output logic er, output int bus_bad, output logic fin);
    stall_n = 0; req_n = 0; bus_bad = 0; rd = '0; er = 1'b0; fin = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wmask = wmask;
    mem_ack = 1'b0;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      #1;
      if (mem_req) begin
        req_n++;
        if (mem_we !== we || mem_addr !== {addr[31:3], 3'b000} ||
            mem_wdata !== wdata || mem_wstrb !== wmask) bus_bad++;
        mem_ack   = (req_n == ack_at);
        mem_rdata = mrdata;
      end else begin
        mem_ack = 1'b0;
      end
      if (cpu_stall) begin
        stall_n++;
        @(negedge clk);
      end else begin
        fin = 1'b1;
        rd  = cpu_rdata;
        er  = cpu_err;
        if (ack_in_done) begin
          mem_ack   = 1'b1;
          mem_rdata = ~mrdata;
        end
      end
    end
  endtask

  task automatic apply(input string name, input logic we, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wmask, input int ack_at,
                       input logic [63:0] mrdata, input logic ack_in_done,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_stall);
    int st, rq, bad;
    logic [31:0] rd;
    logic er, fin;
    run_txn(we, addr, wdata, wmask, ack_at, mrdata, ack_in_done, st, rq, rd, er, bad, fin);
    check({name, " completes"}, 64'(fin), 64'(1));
    check({name, " rdata"},     64'(rd),  64'(exp_rd));
    check({name, " err"},       64'(er),  64'(exp_err));
    check({name, " stall"},     64'(st),  64'(exp_stall));
    check({name, " req_cycles"}, 64'(rq), 64'(exp_stall - 1));
    check({name, " bus_stable"}, 64'(bad), 64'(0));
  endtask

  // Model-driven transaction.
  task automatic txn(input string name, input logic we, input logic [31:0] addr,
                     input logic [63:0] wdata, input logic [7:0] wmask, input int ack_at,
                     input logic [63:0] mrdata, input logic ack_in_done);
    logic [31:0] rd;
    logic er;
    int st;
    model(we, addr, wmask, ack_at, mrdata, rd, er, st);
    apply(name, we, addr, wdata, wmask, ack_at, mrdata, ack_in_done, rd, er, st);
  endtask

  // One idle cycle after a completion: error pulse gone, nothing stalled or requested.
  task automatic idle_check(input string name);
    @(negedge clk);
    cpu_req = 1'b0; mem_ack = 1'b0;
    #1;
    check({name, " idle"}, {61'd0, cpu_stall, cpu_err, mem_req}, 64'd0);
  endtask

  initial begin
    logic [31:0] d_rd;
    logic        d_er;
    int          d_st;
    logic        r_we;
    logic [31:0] r_addr;
    logic [7:0]  r_mask;
    int          r_ack;

    tbl[0] = '{1'b0, 32'h0000_0104, 64'h0, 8'h00, 3, 64'h1122_3344_5566_7788, 32'h1122_3344, 1'b0, 4};
    tbl[1] = '{1'b1, 32'h0000_0200, 64'h0000_0000_AABB_CCDD, 8'h0F, 2, 64'h0, 32'h1122_3344, 1'b0, 3};
    tbl[2] = '{1'b0, 32'h0000_0102, 64'h0, 8'h00, 1, 64'h0, ERRD, 1'b1, 1};
    tbl[3] = '{1'b1, 32'h0000_0208, 64'h1234, 8'h00, 1, 64'h0, 32'h1122_3344, 1'b0, 1};
    tbl[4] = '{1'b0, 32'h0000_0000, 64'h0, 8'h00, 1, 64'hCAFE_BABE_DEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2};
    tbl[5] = '{1'b0, 32'h0000_0008, 64'h0, 8'h00, 1, 64'h0123_4567_89AB_CDEF, 32'h89AB_CDEF, 1'b0, 2};
    tbl[6] = '{1'b0, 32'h0000_010C, 64'h0, 8'h00, 16, 64'h0BAD_F00D_1234_5678, 32'h0BAD_F00D, 1'b0, 17};
    tbl[7] = '{1'b0, 32'h0000_0040, 64'h0, 8'h00, 0, 64'h0, ERRD, 1'b1, 17};
    tbl[8] = '{1'b0, 32'h0000_0001, 64'h0, 8'h00, 1, 64'h0, ERRD, 1'b1, 1};
    tbl[9] = '{1'b1, 32'hFFFF_FFFC, 64'h5555_6666_0000_0000, 8'hF0, 1, 64'h0, 32'h0BAD_F00D, 1'b0, 2};

    nrst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_wmask = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs",
          {cpu_rdata, cpu_stall, cpu_err, mem_req, mem_we, mem_wstrb, 20'd0}, 64'd0);
    check("reset mem_addr",  64'(mem_addr), 64'd0);
    check("reset mem_wdata", mem_wdata,     64'd0);
    @(negedge clk);
    nrst = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      model(tbl[i].we, tbl[i].addr, tbl[i].wmask, tbl[i].ack_at, tbl[i].mrdata, d_rd, d_er, d_st);
      apply($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wmask,
            tbl[i].ack_at, tbl[i].mrdata, 1'b0, tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_stall);
      idle_check($sformatf("vec%0d", i));
    end

    // mem_ack while idle must not move state or touch the load data.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
    #1;
    check("idle_ack stall_req", {62'd0, cpu_stall, mem_req}, 64'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("idle_ack rdata", 64'(cpu_rdata), 64'(model_rdata));
    check("idle_ack state", {62'd0, cpu_stall, cpu_err}, 64'd0);

    // Back-to-back loads, ack in first BUSY cycle, stray ack in DONE of the first.
    txn("b2b0", 1'b0, 32'h0000_0000, 64'h0, 8'h00, 1, 64'hA1A1_A1A1_B2B2_B2B2, 1'b1);
    txn("b2b1", 1'b0, 32'h0000_0008, 64'h0, 8'h00, 1, 64'hC3C3_C3C3_D4D4_D4D4, 1'b0);
    idle_check("b2b");

    // Timeout followed by a late ack that must be ignored.
    txn("tmo", 1'b0, 32'h0000_0048, 64'h0, 8'h00, 0, 64'h0, 1'b0);
    @(negedge clk);
    cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h7777_7777_8888_8888;
    #1;
    check("late_ack idle", {61'd0, cpu_stall, cpu_err, mem_req}, 64'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("late_ack rdata", 64'(cpu_rdata), 64'(model_rdata));

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020; cpu_wmask = 8'h00; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mid busy", 64'(mem_req), 64'd1);
    cpu_req = 1'b0;
    nrst    = 1'b1;
    #1;
    check("rst_mid drop", {61'd0, mem_req, cpu_stall, cpu_err}, 64'd0);
    check("rst_mid rdata", 64'(cpu_rdata), 64'd0);
    model_rdata = '0;
    @(negedge clk);
    nrst = 1'b0;
    txn("post_rst", 1'b0, 32'h0000_0024, 64'h0, 8'h00, 2, 64'h1357_9BDF_2468_ACE0, 1'b0);
    idle_check("post_rst");

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
      r_mask = 8'($urandom);
      if ($urandom_range(0, 5) == 0) r_mask = 8'h00;
      r_ack  = $urandom_range(0, TIMEOUT + 2);
      if ($urandom_range(0, 2) != 0) r_ack = $urandom_range(1, 4);
      txn($sformatf("rnd%0d", n), r_we, r_addr, {$urandom, $urandom}, r_mask, r_ack,
          {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", n));
    end
    idle_check("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
